uart_rx_mmio: RTL and testbench

//  Memory-mapped UART receiver; the receive counterpart of the existing transmit path.

---
 rtl/uart_rx_mmio_pkg.sv | 32 +++
 rtl/uart_rx_mmio_fifo.sv | 62 ++++++
 rtl/uart_rx_mmio.sv | 165 ++++++++++++++++
 tb/tb_uart_rx_mmio.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_mmio_pkg.sv
// Shared definitions for the memory-mapped UART receiver: load addresses,
// status bit positions and receive FSM state encodings.
package uart_rx_mmio_pkg;

    localparam logic [31:0] UART_RX_DATA_ADDR = 32'h0000_0FF0;
    localparam logic [31:0] UART_RX_STAT_ADDR = 32'h0000_0FF4;

    localparam int RXST_VALID = 0;
    localparam int RXST_FULL  = 1;
    localparam int RXST_OVR   = 2;
    localparam int RXST_FERR  = 3;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_IDLE = 3'd4
    } rx_state_e;

    function automatic logic [31:0] rx_status_word(input logic ferr, input logic ovr,
                                                   input logic full, input logic valid);
        logic [31:0] w;
        w             = '0;
        w[RXST_VALID] = valid;
        w[RXST_FULL]  = full;
        w[RXST_OVR]   = ovr;
        w[RXST_FERR]  = ferr;
        return w;
    endfunction

endpackage

// File: rtl/uart_rx_mmio_fifo.sv
// Synchronous byte FIFO for received UART data. A push into a full FIFO is
// still taken when a pop frees a slot in the same cycle; otherwise it is dropped.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic       sysclk,
    input  logic       cpu_resetn,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [7:0] din_i,
    output logic [7:0] dout_o,
    output logic       empty_o,
    output logic       full_o,
    output logic       drop_o
);

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_FULL);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign drop_o  = push_i && !do_push;
    assign dout_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge sysclk or posedge cpu_resetn) begin
        if (cpu_resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge sysclk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/uart_rx_mmio.sv
// 8N1 UART receiver with a byte FIFO and CPU-visible data/status registers.
//   state      | meaning
//   RX_IDLE      | line idle, watching for a falling edge
//   RX_START     | timing to mid start bit, rejecting glitches
//   RX_DATA      | sampling 8 data bits LSB first at mid-bit
//   RX_STOP      | sampling stop bit; push byte or flag framing error
//   RX_WAIT_IDLE | after a framing error, waiting for the line to return high
module uart_rx_mmio import uart_rx_mmio_pkg::*; #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16,
    parameter int FIFO_AW      = 4
) (
    input  logic        sysclk,
    input  logic        cpu_resetn,
    input  logic        uart_rx,
    input  logic        rd_en,
    input  logic        sel_data,
    input  logic        sel_stat,
    output logic [31:0] rd_data,
    output logic        rx_irq
);

    localparam int          CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          irq_q;
    logic          rx_meta_q, rx_sync_q, rx_prev_q;

    logic          push_byte, frame_err;
    logic          pop_req, stat_rd;
    logic [7:0]    fifo_dout;
    logic          fifo_empty, fifo_full, fifo_drop;

    // Two-flop synchroniser plus one more stage for falling-edge detection.
    always_ff @(posedge sysclk or posedge cpu_resetn) begin
        if (cpu_resetn) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push_byte = 1'b0;
        frame_err = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_sync_q) begin
                        push_byte = 1'b1;
                        state_d   = RX_IDLE;
                    end else begin
                        frame_err = 1'b1;
                        state_d   = RX_WAIT_IDLE;
                    end
                end
            end
            RX_WAIT_IDLE: begin
                cnt_d = '0;
                if (rx_sync_q) state_d = RX_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = RX_IDLE;
            end
        endcase
    end

    // A simultaneous data+status select is treated as a data access only.
    assign pop_req = rd_en && sel_data;
    assign stat_rd = rd_en && sel_stat && !sel_data;

    always_comb begin
        ferr_d = ferr_q;
        ovr_d  = ovr_q;
        if (stat_rd) begin
            ferr_d = 1'b0;
            ovr_d  = 1'b0;
        end
        if (frame_err) ferr_d = 1'b1;
        if (fifo_drop) ovr_d  = 1'b1;
    end

    always_ff @(posedge sysclk or posedge cpu_resetn) begin
        if (cpu_resetn) begin
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
            irq_q     <= !fifo_empty;
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .sysclk     (sysclk),
        .cpu_resetn (cpu_resetn),
        .push_i     (push_byte),
        .pop_i      (pop_req),
        .din_i      (shift_q),
        .dout_o     (fifo_dout),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full),
        .drop_o     (fifo_drop)
    );

    always_comb begin
        rd_data = '0;
        if (sel_data) begin
            if (!fifo_empty) rd_data = {24'b0, fifo_dout};
        end else if (sel_stat) begin
            rd_data = rx_status_word(ferr_q, ovr_q, fifo_full, !fifo_empty);
        end
    end

    assign rx_irq = irq_q;

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Bench for uart_rx_mmio: directed scenarios plus random traffic, checked every
// cycle against a frame-level model (byte queue, flags, scheduled frame completions).
module tb_uart_rx_mmio;

    localparam int C     = 16;
    localparam int H     = C / 2;
    localparam int DEPTH = 16;
    // Start bit driven just after posedge k: two sync stages, one detect cycle,
    // half a bit to mid start, then nine full bits to mid stop.
    localparam int LAT   = H + 3 + 9 * C;

    logic        sysclk = 1'b0;
    logic        cpu_resetn;
    logic        uart_rx;
    logic        rd_en;
    logic        sel_data;
    logic        sel_stat;
    logic [31:0] rd_data;
    logic        rx_irq;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         t;
        bit         ferr;
        logic [7:0] b;
    } ev_t;

    ev_t        ev[$];
    logic [7:0] mq[$];
    bit         ferr_m = 0, ovr_m = 0, irq_m = 0;
    int         cyc = 0;
    ev_t        e;
    bit         m_pop, m_clr, m_setf, m_seto, m_full;
    logic [31:0] exp_rd;
    bit         rnd_done;
    int         rd_rate;

    uart_rx_mmio #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (DEPTH),
        .FIFO_AW      (4)
    ) dut (
        .sysclk     (sysclk),
        .cpu_resetn (cpu_resetn),
        .uart_rx    (uart_rx),
        .rd_en      (rd_en),
        .sel_data   (sel_data),
        .sel_stat   (sel_stat),
        .rd_data    (rd_data),
        .rx_irq     (rx_irq)
    );

    always #5 sysclk = ~sysclk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
        end
    endfunction

    // Reference model: frame completions land at scheduled cycles.
    always @(posedge sysclk or posedge cpu_resetn) begin
        if (cpu_resetn) begin
            mq.delete();
            ev.delete();
            ferr_m = 0;
            ovr_m  = 0;
            irq_m  = 0;
        end else begin
            cyc++;
            irq_m  = (mq.size() != 0);
            m_pop  = rd_en && sel_data && (mq.size() != 0);
            m_clr  = rd_en && sel_stat && !sel_data;
            m_full = (mq.size() == DEPTH);
            m_setf = 0;
            m_seto = 0;
            if (m_pop) void'(mq.pop_front());
            while (ev.size() != 0 && ev[0].t <= cyc) begin
                e = ev.pop_front();
                if (e.ferr)              m_setf = 1;
                else if (!m_full || m_pop) mq.push_back(e.b);
                else                     m_seto = 1;
            end
            if (m_clr) begin
                ferr_m = 0;
                ovr_m  = 0;
            end
            if (m_setf) ferr_m = 1;
            if (m_seto) ovr_m  = 1;
        end
    end

    always @(negedge sysclk) begin
        exp_rd = '0;
        if (sel_data) begin
            if (mq.size() != 0) exp_rd = {24'b0, mq[0]};
        end else if (sel_stat) begin
            exp_rd = {28'b0, ferr_m, ovr_m, mq.size() == DEPTH, mq.size() != 0};
        end
        chk("rd_data", rd_data, exp_rd);
        chk("rx_irq", {31'b0, rx_irq}, {31'b0, irq_m});
    end

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic idle(input int n);
        uart_rx = 1'b1;
        repeat (n) step();
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop);
        ev.push_back('{t: cyc + LAT, ferr: !stop, b: b});
        uart_rx = 1'b0;
        repeat (C) step();
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (C) step();
        end
        uart_rx = stop;
        repeat (C) step();
    endtask

    task automatic do_read(input bit dsel, input logic [31:0] expv, input string nm);
        rd_en    = 1'b1;
        sel_data = dsel;
        sel_stat = !dsel;
        @(negedge sysclk);
        chk(nm, rd_data, expv);
        step();
        rd_en    = 1'b0;
        sel_data = 1'b0;
        sel_stat = 1'b0;
    endtask

    initial begin
        logic [7:0] ab;
        uart_rx    = 1'b1;
        rd_en      = 1'b0;
        sel_data   = 1'b0;
        sel_stat   = 1'b0;
        cpu_resetn = 1'b0;
        #1 cpu_resetn = 1'b1;
        repeat (4) @(posedge sysclk);
        #1 cpu_resetn = 1'b0;
        idle(5);
        do_read(0, 32'h0, "reset_stat");
        do_read(1, 32'h0, "reset_data");

        // 1: single frame
        send_frame(8'hA5, 1);
        idle(4);
        do_read(0, 32'h1, "t1_stat");
        do_read(1, 32'hA5, "t1_data");
        do_read(0, 32'h0, "t1_stat_empty");

        // 2: back-to-back frames, irq lags the final pop
        send_frame(8'h00, 1);
        send_frame(8'hFF, 1);
        idle(4);
        do_read(1, 32'h00, "t2_first");
        rd_en    = 1'b1;
        sel_data = 1'b1;
        @(negedge sysclk);
        chk("t2_second", rd_data, 32'hFF);
        step();
        rd_en    = 1'b0;
        sel_data = 1'b0;
        @(negedge sysclk);
        chk("t2_irq_hold", {31'b0, rx_irq}, 32'h1);
        step();
        @(negedge sysclk);
        chk("t2_irq_drop", {31'b0, rx_irq}, 32'h0);
        step();

        // 3: short low glitch
        uart_rx = 1'b0;
        repeat (4) step();
        idle(40);
        do_read(0, 32'h0, "t3_stat");

        // 4: framing error followed by a held break
        send_frame(8'h3C, 0);
        repeat (100) step();
        idle(20);
        do_read(0, 32'h8, "t4_ferr");
        do_read(0, 32'h0, "t4_clr");
        send_frame(8'h11, 1);
        idle(4);
        do_read(1, 32'h11, "t4_next");

        // 5: overrun, then pop and push in the same cycle while full
        for (int i = 1; i <= 17; i++) send_frame(8'(i), 1);
        idle(4);
        do_read(0, 32'h7, "t5_stat");
        fork
            send_frame(8'h99, 1);
            begin
                repeat (LAT - 1) step();
                rd_en    = 1'b1;
                sel_data = 1'b1;
                @(negedge sysclk);
                chk("t5_pp_head", rd_data, 32'h1);
                step();
                rd_en    = 1'b0;
                sel_data = 1'b0;
            end
        join
        idle(4);
        do_read(0, 32'h3, "t5_full_no_ovr");
        for (int i = 2; i <= 16; i++) do_read(1, 32'(i), "t5_data");
        do_read(1, 32'h99, "t5_last");
        do_read(0, 32'h0, "t5_empty");

        // 6: reset in the middle of data bit 4
        send_frame(8'h77, 1);
        idle(4);
        ab = 8'hC3;
        ev.push_back('{t: cyc + LAT, ferr: 1'b0, b: ab});
        uart_rx = 1'b0;
        repeat (C) step();
        for (int i = 0; i < 4; i++) begin
            uart_rx = ab[i];
            repeat (C) step();
        end
        uart_rx = ab[4];
        repeat (C / 2) step();
        cpu_resetn = 1'b1;
        uart_rx    = 1'b1;
        sel_stat   = 1'b1;
        @(negedge sysclk);
        chk("t6_rst_stat", rd_data, 32'h0);
        chk("t6_rst_irq", {31'b0, rx_irq}, 32'h0);
        step();
        sel_stat = 1'b0;
        repeat (2) step();
        cpu_resetn = 1'b0;
        idle(10);
        send_frame(8'h5A, 1);
        idle(4);
        do_read(1, 32'h5A, "t6_data");
        do_read(0, 32'h0, "t6_stat");

        // Random traffic: sparse reads first (overruns), then busy reads.
        rnd_done = 0;
        rd_rate  = 300;
        fork
            begin
                for (int n = 0; n < 36; n++) begin
                    bit sb;
                    if (n == 24) rd_rate = 4;
                    sb = ($urandom_range(0, 7) != 0);
                    send_frame(8'($urandom), sb);
                    idle(sb ? $urandom_range(0, 12) : $urandom_range(4, 12));
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    rd_en    = ($urandom_range(0, rd_rate) == 0);
                    sel_data = 1'($urandom);
                    sel_stat = 1'($urandom);
                    step();
                end
                rd_en    = 1'b0;
                sel_data = 1'b0;
                sel_stat = 1'b0;
            end
        join

        rd_en    = 1'b1;
        sel_data = 1'b1;
        repeat (DEPTH + 4) step();
        sel_data = 1'b0;
        sel_stat = 1'b1;
        step();
        rd_en    = 1'b0;
        sel_stat = 1'b0;
        do_read(0, 32'h0, "final_stat");
        do_read(1, 32'h0, "final_data");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
